// File: rtl/rd_result_collector.sv
// rd_result_collector
//   Sits behind the 7-cycle pipelined recursive-doubling adder. The adder never stalls,
//   so operations are only issued while a result slot is guaranteed downstream. Each
//   accepted issue launches a valid/tag token down a LATENCY-deep pipe aligned with the
//   adder. When the token reaches the last stage, {sum_in, carry_in, tag} is written
//   into a DEPTH-entry FIFO that is drained through a valid/ready port.
//
//   Credit rule: tokens in flight plus FIFO occupancy never exceed DEPTH. in_ready is
//   therefore derived from registered state only, and a pop frees its credit one cycle
//   later.
//
//   Optional build macro: RD_COLLECTOR_STATS_EN
//     defined     -> stat_ops / stat_carry counters (16-bit, wrapping) count popped
//                    results and popped results whose carry-out was set.
//     not defined -> counters and their ports are absent.
module rd_result_collector #(
  parameter  int WIDTH   = 32,
  parameter  int LATENCY = 7,
  parameter  int DEPTH   = 8,
  parameter  int TAGW    = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [TAGW-1:0]  in_tag,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_in,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic [TAGW-1:0]  out_tag,
  output logic [LW-1:0]    level
`ifdef RD_COLLECTOR_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_carry
`endif
);

  localparam logic [LW:0] CREDITS = (LW+1)'(DEPTH);

  logic               accept;
  logic               capture;
  logic               pop;
  logic [LW:0]        outstanding;

  logic [LATENCY-1:0] pipe_v;
  logic [TAGW-1:0]    pipe_tag [LATENCY];
  logic [LW-1:0]      inflight;

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [WIDTH-1:0]   mem_sum  [DEPTH];
  logic [TAGW-1:0]    mem_tag  [DEPTH];
  logic [DEPTH-1:0]   mem_carry;

  // Credit check and handshakes; in_ready depends only on flops.
  assign outstanding = {1'b0, inflight} + {1'b0, level};
  assign in_ready    = (outstanding < CREDITS);
  assign accept      = in_valid & in_ready;
  assign capture     = pipe_v[LATENCY-1];
  assign out_valid   = (level != '0);
  assign pop         = out_valid & out_ready;

  // Head outputs come straight from the storage flops, forced to zero when empty.
  assign out_sum   = out_valid ? mem_sum[rd_ptr]   : '0;
  assign out_carry = out_valid ? mem_carry[rd_ptr] : 1'b0;
  assign out_tag   = out_valid ? mem_tag[rd_ptr]   : '0;

  // Token pipe: shifts every cycle, a bubble enters whenever nothing is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_v <= {pipe_v[LATENCY-2:0], accept};
      for (int i = LATENCY-1; i > 0; i--) pipe_tag[i] <= pipe_tag[i-1];
      pipe_tag[0] <= accept ? in_tag : '0;
    end
  end

  // Number of valid tokens currently in the pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= '0;
    else     inflight <= inflight + LW'(accept) - LW'(capture);
  end

  // Result storage; contents are only observed through valid entries, so no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem_sum[wr_ptr]   <= sum_in;
      mem_carry[wr_ptr] <= carry_in;
      mem_tag[wr_ptr]   <= pipe_tag[LATENCY-1];
    end
  end

  // FIFO pointers and exact occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({capture, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

`ifdef RD_COLLECTOR_STATS_EN
  // Popped-result counters, wrapping at 2^16.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_carry <= '0;
    end else if (pop) begin
      stat_ops <= stat_ops + 16'd1;
      if (out_carry) stat_carry <= stat_carry + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rd_result_collector.sv
// Bench for rd_result_collector: emulates the adder from a per-cycle operand history and
// predicts results with a queue-based model of issued operations and buffered results.
`define CHK(t, o, e) begin tests++; assert ((o) === (e)) else begin fails++; $error("FAIL %s: got %0h expected %0h", t, o, e); end end

module tb_rd_result_collector;
  localparam int WIDTH = 32;
  localparam int LAT   = 7;
  localparam int DEPTH = 8;
  localparam int TAGW  = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int HIST  = 4096;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [TAGW-1:0]  in_tag = '0;
  logic             in_ready;
  logic [WIDTH-1:0] sum_in = '0;
  logic             carry_in = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic [TAGW-1:0]  out_tag;
  logic [LW-1:0]    level;
`ifdef RD_COLLECTOR_STATS_EN
  logic [15:0]      stat_ops;
  logic [15:0]      stat_carry;
`endif

  rd_result_collector #(.WIDTH(WIDTH), .LATENCY(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_tag(in_tag), .in_ready(in_ready),
    .sum_in(sum_in), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .out_tag(out_tag),
    .level(level)
`ifdef RD_COLLECTOR_STATS_EN
    , .stat_ops(stat_ops), .stat_carry(stat_carry)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int              due;
    logic [WIDTH-1:0] s;
    logic            c;
    logic [TAGW-1:0] t;
  } op_t;

  op_t pend[$];
  op_t fifo[$];

  logic [WIDTH-1:0] opa [HIST];
  logic [WIDTH-1:0] opb [HIST];
  logic [WIDTH-1:0] cur_a = '0;
  logic [WIDTH-1:0] cur_b = '0;
  logic [15:0]      m_ops = '0;
  logic [15:0]      m_carry = '0;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int dut_acc = 0;

  // One clock cycle: drive adder output, compare against model, advance model and clock.
  task automatic step();
    logic [WIDTH:0] r;
    logic [WIDTH:0] sab;
    logic exp_rdy, exp_val, acc, pop;
    op_t h;
    if (cyc >= HIST) begin
      fails++;
      $display("FAIL cycle_budget: got %0d expected < %0d", cyc, HIST);
      $fatal(1, "cycle budget exceeded");
    end
    opa[cyc] = cur_a;
    opb[cyc] = cur_b;
    if (cyc >= LAT) r = {1'b0, opa[cyc-LAT]} + {1'b0, opb[cyc-LAT]};
    else            r = '0;
    sum_in   = r[WIDTH-1:0];
    carry_in = r[WIDTH];

    exp_rdy = (pend.size() + fifo.size()) < DEPTH;
    exp_val = (fifo.size() != 0);
    `CHK("in_ready",  in_ready,  exp_rdy)
    `CHK("out_valid", out_valid, exp_val)
    `CHK("level",     level,     LW'(fifo.size()))
    `CHK("no_ovf",    (level <= LW'(DEPTH)), 1'b1)
    if (exp_val) begin
      h = fifo[0];
      `CHK("out_sum",   out_sum,   h.s)
      `CHK("out_carry", out_carry, h.c)
      `CHK("out_tag",   out_tag,   h.t)
    end else begin
      `CHK("out_sum0",  out_sum,   {WIDTH{1'b0}})
      `CHK("out_tag0",  out_tag,   {TAGW{1'b0}})
    end
`ifdef RD_COLLECTOR_STATS_EN
    `CHK("stat_ops",   stat_ops,   m_ops)
    `CHK("stat_carry", stat_carry, m_carry)
`endif
    if (in_valid && in_ready) dut_acc++;

    acc = in_valid && exp_rdy;
    pop = exp_val && out_ready;
    if (pop) begin
      m_ops++;
      if (fifo[0].c) m_carry++;
      void'(fifo.pop_front());
    end
    while (pend.size() != 0 && pend[0].due == cyc) fifo.push_back(pend.pop_front());
    if (acc) begin
      sab = {1'b0, cur_a} + {1'b0, cur_b};
      pend.push_back('{cyc + LAT, sab[WIDTH-1:0], sab[WIDTH], in_tag});
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic [TAGW-1:0] t, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b);
    in_valid = 1'b1; in_tag = t; cur_a = a; cur_b = b;
    step();
    in_valid = 1'b0; cur_a = '0; cur_b = '0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    `CHK("rst_in_ready",  in_ready,  1'b1)
    `CHK("rst_out_valid", out_valid, 1'b0)
    `CHK("rst_level",     level,     {LW{1'b0}})
    pend.delete();
    fifo.delete();
    m_ops = '0;
    m_carry = '0;
    opa[cyc] = '0;
    opb[cyc] = '0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < HIST; i++) begin opa[i] = '0; opb[i] = '0; end
    #1;
    `CHK("init_in_ready",  in_ready,  1'b1)
    `CHK("init_out_valid", out_valid, 1'b0)
    `CHK("init_level",     level,     {LW{1'b0}})
    `CHK("init_out_sum",   out_sum,   {WIDTH{1'b0}})
    `CHK("init_out_carry", out_carry, 1'b0)
    `CHK("init_out_tag",   out_tag,   {TAGW{1'b0}})
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    // Single op: 2+3 with tag 3, visible LATENCY+1 cycles after issue.
    out_ready = 1'b0;
    issue(4'd3, 32'd2, 32'd3);
    idle(LAT - 1);
    `CHK("t1_pre_valid", out_valid, 1'b0)
    step();
    `CHK("t1_valid", out_valid, 1'b1)
    `CHK("t1_sum",   out_sum,   32'h0000_0005)
    `CHK("t1_tag",   out_tag,   4'd3)
    `CHK("t1_level", level,     LW'(1))
    out_ready = 1'b1;
    idle(2);

    // Back-to-back: tags 0..7 with consumer always ready.
    for (int i = 0; i < 8; i++) issue(TAGW'(i), $urandom, $urandom);
    idle(LAT + 3);

    // Backpressure: exactly DEPTH accepts, then drain in order.
    out_ready = 1'b0;
    dut_acc = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_tag = TAGW'(i); cur_a = $urandom; cur_b = $urandom;
      step();
    end
    in_valid = 1'b0;
    `CHK("bp_accepts", dut_acc, DEPTH)
    `CHK("bp_level",   level,   LW'(DEPTH))
    `CHK("bp_ready",   in_ready, 1'b0)
    out_ready = 1'b1;
    idle(DEPTH + 2);
    `CHK("bp_drained", level, {LW{1'b0}})

    // Simultaneous push and pop at level 4.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(TAGW'(8 + i), $urandom, $urandom);
    idle(3);
    issue(4'd12, $urandom, $urandom);
    idle(LAT - 1);
    `CHK("pp_level_before", level, LW'(4))
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    `CHK("pp_level_after", level, LW'(4))
    `CHK("pp_head_tag",    out_tag, 4'd9)
    out_ready = 1'b1;
    idle(6);

    // Carry: 0x8000_0000 + 0x8000_0000 -> sum 0, carry 1.
    issue(4'd5, 32'h8000_0000, 32'h8000_0000);
    out_ready = 1'b0;
    idle(LAT);
    `CHK("cy_sum",   out_sum,   32'h0000_0000)
    `CHK("cy_carry", out_carry, 1'b1)
    out_ready = 1'b1;
    idle(2);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_tag    = TAGW'($urandom);
      cur_a     = (i % 17 == 0) ? 32'hFFFF_FFFF : $urandom;
      cur_b     = $urandom;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(LAT + DEPTH + 2);

    // Reset mid-flight: 2 results buffered, 3 tokens in the pipe.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) issue(TAGW'(i + 1), $urandom, $urandom);
    idle(4);
    `CHK("rmf_level_pre", level, LW'(2))
    pulse_reset();
    out_ready = 1'b1;
    idle(LAT + 2);
    `CHK("rmf_level_post", level, {LW{1'b0}})

    // Traffic after reset still flows normally.
    issue(4'd7, 32'h1234_5678, 32'h0000_0001);
    idle(LAT + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
